// File: rtl/frame_tx_arbiter.sv
// Round-robin arbiter that shares one byte-wide link among NUM_REQ frame sources.
// Each frame has a generated 2-byte header (AF AA or BA 55) followed by payload pulled from the winner.
module frame_tx_arbiter #(
    parameter int         NUM_REQ   = 4,
    parameter logic [7:0] IDLE_BYTE = 8'h00,
    parameter int         FRAME_LEN = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     hdr_sel,
    input  logic [8*NUM_REQ-1:0]   pl_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     pl_rd,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    output logic [3:0]             tx_byte_pos,
    output logic                   tx_sof,
    output logic                   frame_done,
    output logic [15:0]            frame_cnt
);

    localparam int               IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0]       LAST_POS = 4'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state_reg, state_next;
    logic [3:0]         cnt_reg, cnt_next;
    logic [IDX_W-1:0]   gidx_reg, gidx_next;
    logic [IDX_W-1:0]   ptr_reg, ptr_next;
    logic               hsel_reg, hsel_next;
    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic [7:0]         tx_data_reg, tx_data_next;
    logic [15:0]        frame_cnt_reg, frame_cnt_next;

    logic [7:0]         pl_byte [NUM_REQ];
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic [IDX_W:0]     cand;
    logic               at_last;
    logic               arb_point;

    // Payload pops happen only between the header and the last byte of the granted requester.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign pl_byte[gi] = pl_data[8*gi +: 8];
            assign pl_rd[gi]   = (state_reg == SEND) && (cnt_reg != 4'd0) &&
                                 (cnt_reg != LAST_POS) && (gidx_reg == IDX_W'(gi));
        end
    endgenerate

    // Scan from the far end towards ptr so the last hit is the nearest requester at or after ptr.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_reg} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ))
                cand = cand - (IDX_W+1)'(NUM_REQ);
            if (req[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign at_last   = (cnt_reg == LAST_POS);
    assign arb_point = (state_reg == IDLE) || at_last;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        gidx_next      = gidx_reg;
        hsel_next      = hsel_reg;
        ptr_next       = ptr_reg;
        grant_next     = grant_reg;
        tx_data_next   = tx_data_reg;
        frame_cnt_next = frame_cnt_reg;

        if ((state_reg == SEND) && at_last)
            frame_cnt_next = frame_cnt_reg + 16'd1;

        if (arb_point) begin
            cnt_next = 4'd0;
            if (win_found) begin
                state_next          = SEND;
                gidx_next           = win_idx;
                hsel_next           = hdr_sel[win_idx];
                ptr_next            = (win_idx == LAST_IDX) ? '0 : win_idx + IDX_W'(1);
                grant_next          = '0;
                grant_next[win_idx] = 1'b1;
                tx_data_next        = hdr_sel[win_idx] ? 8'hBA : 8'hAF;
            end else begin
                state_next   = IDLE;
                grant_next   = '0;
                tx_data_next = IDLE_BYTE;
            end
        end else begin
            cnt_next     = cnt_reg + 4'd1;
            tx_data_next = (cnt_reg == 4'd0) ? (hsel_reg ? 8'h55 : 8'hAA) : pl_byte[gidx_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            gidx_reg      <= '0;
            hsel_reg      <= 1'b0;
            ptr_reg       <= '0;
            grant_reg     <= '0;
            tx_data_reg   <= IDLE_BYTE;
            frame_cnt_reg <= 16'd0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            gidx_reg      <= gidx_next;
            hsel_reg      <= hsel_next;
            ptr_reg       <= ptr_next;
            grant_reg     <= grant_next;
            tx_data_reg   <= tx_data_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    assign grant       = grant_reg;
    assign tx_data     = tx_data_reg;
    assign tx_valid    = (state_reg == SEND);
    assign tx_byte_pos = (state_reg == SEND) ? cnt_reg : 4'd0;
    assign tx_sof      = (state_reg == SEND) && (cnt_reg == 4'd0);
    assign frame_done  = (state_reg == SEND) && at_last;
    assign frame_cnt   = frame_cnt_reg;

endmodule
